// File: rtl/data_mem_resp.sv
// ============================================================================
//  Module      : data_mem_resp
//  Description : Single-outstanding RV32I data memory with a fixed request to
//                response latency. Byte/half/word loads with sign or zero
//                extension, byte-lane stores, range and funct3 error checking.
//                Optional macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned
//                half/word accesses into errors instead of force-aligning.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int CNT_W    = 3;
    localparam int CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [2:0]         funct3_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_we;
    logic [31:0]        w_addr;
    logic [2:0]         w_f3;
    logic [31:0]        w_wd_in;
    logic [AW-1:0]      w_idx;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_shift;
    logic [15:0]        w_half;
    logic               w_f3_err;
    logic               w_range_err;
    logic               w_align_err;
    logic               w_err;
    logic [31:0]        w_rdata;
    logic [31:0]        w_mask;
    logic [31:0]        w_wd;
    logic               w_mem_we;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Acceptance is suppressed while reset is held so no access can slip through
    assign w_accept = req_valid && req_ready && rst_n;

    // Next-state and latency counter; the access happens on the edge into RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With LATENCY=1 the access uses the live request; otherwise the captured copy
    always_comb begin
        w_we    = (state_q == S_IDLE) ? req_we     : we_q;
        w_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
        w_f3    = (state_q == S_IDLE) ? req_funct3 : funct3_q;
        w_wd_in = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    end

    assign w_idx       = w_addr[AW+1:2];
    assign w_rd_word   = mem_q[w_idx];
    assign w_range_err = |w_addr[31:AW+2];
    assign w_shift     = w_rd_word >> {w_addr[1:0], 3'b000};
    assign w_half      = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Legal funct3 encodings differ between loads and stores
    always_comb begin
        w_f3_err = 1'b1;
        if (w_we) begin
            w_f3_err = (w_f3 > 3'b010);
        end else begin
            case (w_f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_err = 1'b0;
                default:                                w_f3_err = 1'b1;
            endcase
        end
    end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign w_align_err = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                         ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    assign w_align_err = 1'b0;
`endif

    assign w_err = w_f3_err || w_range_err || w_align_err;

    // Load extraction and extension; errors and stores return zero
    always_comb begin
        w_rdata = 32'h0;
        if (!w_we && !w_err) begin
            case (w_f3)
                3'b000:  w_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
                3'b100:  w_rdata = {24'h0, w_shift[7:0]};
                3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
                3'b101:  w_rdata = {16'h0, w_half};
                3'b010:  w_rdata = w_rd_word;
                default: w_rdata = 32'h0;
            endcase
        end
    end

    // Store lane mask and replicated write data; half/word ignore low address bits
    always_comb begin
        w_mask = 32'h0;
        w_wd   = 32'h0;
        case (w_f3[1:0])
            2'b00: begin
                w_mask = 32'h0000_00FF << {w_addr[1:0], 3'b000};
                w_wd   = {4{w_wd_in[7:0]}};
            end
            2'b01: begin
                w_mask = w_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wd   = {2{w_wd_in[15:0]}};
            end
            2'b10: begin
                w_mask = 32'hFFFF_FFFF;
                w_wd   = w_wd_in;
            end
            default: begin
                w_mask = 32'h0;
                w_wd   = 32'h0;
            end
        endcase
    end

    assign w_mem_we = w_enter_resp && w_we && !w_err && rst_n;

    // FSM state, counter, request capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (w_enter_resp) begin
                rdata_q <= w_rdata;
                err_q   <= w_err;
            end else if ((state_q == S_RESP) && rsp_ready) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_idx] <= (w_rd_word & ~w_mask) | (w_wd & w_mask);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ============================================================================
//  Module      : tb_data_mem_resp
//  Description : Directed self-checking bench for data_mem_resp (LATENCY=3,
//                DEPTH_WORDS=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_resp;

    localparam int LAT   = 3;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests;
    int fails;

    data_mem_resp #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency, optionally stall the response, then complete it
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int hold, input string tag);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        #1;
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0;
        for (int i = 1; i <= LAT; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            check({tag, ".lat_valid"}, {31'h0, rsp_valid}, {31'h0, (i == LAT)});
            check({tag, ".busy"}, {31'h0, req_ready}, 32'h0);
        end
        for (int h = 0; h < hold; h++) begin
            check({tag, ".hold_valid"}, {31'h0, rsp_valid}, 32'h1);
            check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, ".hold_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
            check({tag, ".hold_ready"}, {31'h0, req_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, ".done_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.req_ready", {31'h0, req_ready}, 32'h1);

        // Word store and load, then sub-word loads
        do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw10");
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw10");
        do_req(1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 0, "lb13");
        do_req(1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0, 0, "lbu13");
        do_req(1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, 0, "lh10");
        do_req(1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 0, "lhu12");

        // Byte and half stores touch only their lanes
        do_req(1'b1, 32'h11, 3'b000, 32'hAAAAAA55, 32'h0, 1'b0, 0, "sb11");
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0, 0, "lw_sb");
        do_req(1'b1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 1'b0, 0, "sh12");
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, 5, "lw_hold");

        // Out-of-range store must not alias onto word 0
        do_req(1'b1, 32'h0, 3'b010, 32'h01020304, 32'h0, 1'b0, 0, "sw0");
        do_req(1'b1, 32'h40, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "sw_oor");
        do_req(1'b0, 32'h0, 3'b010, 32'h0, 32'h01020304, 1'b0, 0, "lw0");

        // Illegal funct3 for load and store
        do_req(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 0, "ld_f3");
        do_req(1'b1, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 0, "st_f3");
        do_req(1'b0, 32'h10, 3'b110, 32'h0, 32'h0, 1'b1, 0, "ld_f3_110");
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, 0, "lw_after_err");

        // Misaligned word load
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        do_req(1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1, 0, "lw12");
`else
        do_req(1'b0, 32'h12, 3'b010, 32'h0, 32'h123455EF, 1'b0, 0, "lw12");
`endif

        // Reset during WAIT discards a pending store
        do_req(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw20");
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = 3'b010;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstw.valid_low", {31'h0, rsp_valid}, 32'h0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check("rstw.no_rsp", {31'h0, rsp_valid}, 32'h0);
            check("rstw.ready", {31'h0, req_ready}, 32'h1);
        end
        do_req(1'b0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 0, "lw20");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16 to 65536.
REQ-002 Parameter LATENCY, default 1: cycles from request acceptance to rsp_valid; 1 to 8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address, little-endian.
REQ-009 req_funct3  input  3  RV32I load/store funct3 (size and signedness).
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was illegal and had no effect.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; at most one request outstanding.
REQ-016 req_ready = 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1; req_we, req_addr, req_funct3 and req_wdata are captured then.
REQ-017 On acceptance in cycle N: LATENCY=1 goes IDLE->RESP; LATENCY>1 goes IDLE->WAIT, stays LATENCY-1 cycles on a down-counter, then ->RESP; rsp_valid rises at edge N+LATENCY.
REQ-018 Memory read/write occurs on the edge entering RESP, and never at any other time.
REQ-019 Loads: 000 lb and 100 lbu select byte addr[1:0]; 001 lh and 101 lhu select half addr[1]; 010 lw selects the whole word; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-020 Stores: 000 sb writes byte lane addr[1:0] from wdata[7:0]; 001 sh writes half lane addr[1] from wdata[15:0]; 010 sw writes all four lanes; untouched lanes are preserved.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr >= 4*DEPTH_WORDS raises rsp_err=1.
REQ-022 Undefined funct3 (loads 011/110/111, stores 011-111) raises rsp_err=1.
REQ-023 On any error: no write is performed and rsp_rdata = 0.
REQ-024 In RESP, rsp_valid = 1 and rsp_rdata/rsp_err hold stable until rsp_ready = 1; on that edge the FSM returns to IDLE.
REQ-025 rsp_ready = 1 outside RESP has no effect; a new request is not accepted in the same cycle as the response handshake, so back-to-back throughput is one request per LATENCY+1 cycles.

Reset
REQ-026 rst_n = 0 immediately forces: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
REQ-027 Reset in WAIT discards the pending request, and no write occurs; reset in RESP drops the response; memory contents are not cleared by reset.

Configuration
REQ-028 Macro DATA_MEM_MISALIGN_TRAP_EN: when defined, lh/lhu/sh with addr[0]=1 and lw/sw with addr[1:0]!=0 raise rsp_err=1 with no write; when undefined, the offending low address bits are treated as 0 and the access is force-aligned with no error.

Verification
REQ-029 LATENCY=3: sw addr 0x10 data 0xDEADBEEF accepted at cycle 0 -> rsp_valid at cycle 3, rsp_err 0; a following lw 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-030 After that sw: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-031 sb 0x11 data 0x55, then lw 0x10 -> 0xDEAD55EF.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0 throughout; rsp_ready=1 -> IDLE next edge.
REQ-033 sw at addr 4*DEPTH_WORDS -> rsp_err 1, with no memory change; funct3 011 load -> rsp_err 1, rsp_rdata 0; lw 0x12 -> rsp_err 1 with DATA_MEM_MISALIGN_TRAP_EN, and data of word 0x10 without it.
REQ-034 rst_n pulsed low during WAIT of sw 0x20 data 0x12345678 -> no response; lw 0x20 returns the pre-reset contents.
